// File: rtl/sig_meas.sv
// ============================================================================
// sig_meas : ADC min/max/peak-to-peak and period measurement     rev 1.0
// ============================================================================
`default_nettype none

module sig_meas #(
  parameter int WIN_LEN = 1024,
  parameter int HYST    = 4,
  parameter int TMO     = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ad_data,
  input  logic        start,
  output logic        ad_clk,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic [7:0]  vpp,
  output logic [11:0] period
);

  localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int TCW = $clog2(TMO + 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO - 1);
  localparam logic [8:0]     HYST9    = 9'(HYST);
  localparam logic [8:0]     FLAT_LIM = 9'(2 * HYST);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEAK  = 3'd1,
    ARM0  = 3'd2,
    TRIG0 = 3'd3,
    ARM1  = 3'd4,
    TRIG1 = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_s, r_max, r_min, r_hi, r_lo;
  logic [7:0]      r_vmax, r_vmin, r_vpp;
  logic [11:0]     r_period, r_pcnt;
  logic            r_err;
  logic [WCW-1:0]  r_wcnt;
  logic [TCW-1:0]  r_tcnt;

  logic [7:0] w_cur_max, w_cur_min, w_vpp, w_hi, w_lo;
  logic [8:0] w_sum, w_thr, w_hi9;
  logic       w_first, w_peak_last, w_flat, w_edge_st, w_tmo, w_rise, w_fall, w_hit1;

  assign ad_clk = clk;

  // Window statistics include the sample being consumed this cycle so the
  // thresholds can be registered on the very edge that leaves PEAK.
  assign w_first     = (r_wcnt == '0);
  assign w_cur_max   = (w_first || r_s > r_max) ? r_s : r_max;
  assign w_cur_min   = (w_first || r_s < r_min) ? r_s : r_min;
  assign w_vpp       = w_cur_max - w_cur_min;
  assign w_sum       = {1'b0, w_cur_max} + {1'b0, w_cur_min};
  assign w_thr       = w_sum >> 1;
  assign w_hi9       = w_thr + HYST9;
  assign w_hi        = (w_hi9 > 9'd255) ? 8'hFF : w_hi9[7:0];
  assign w_lo        = (w_thr < HYST9) ? 8'd0 : 8'(w_thr - HYST9);
  assign w_flat      = ({1'b0, w_vpp} <= FLAT_LIM);
  assign w_peak_last = (r_state == PEAK) && (r_wcnt == WIN_LAST);

  assign w_edge_st = (r_state == ARM0) || (r_state == TRIG0) ||
                     (r_state == ARM1) || (r_state == TRIG1);
  assign w_tmo     = w_edge_st && (r_tcnt == TMO_LAST);
  assign w_rise    = (r_s >= r_hi);
  assign w_fall    = (r_s <= r_lo);
  assign w_hit1    = (r_state == TRIG1) && w_rise;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    done   = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_next = PEAK;
      PEAK:    if (w_peak_last) w_next = w_flat ? DONE : ARM0;
      ARM0:    if (w_tmo) w_next = DONE; else if (w_fall) w_next = TRIG0;
      TRIG0:   if (w_tmo) w_next = DONE; else if (w_rise) w_next = ARM1;
      ARM1:    if (w_tmo) w_next = DONE; else if (w_fall) w_next = TRIG1;
      TRIG1:   if (w_rise || w_tmo) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s      <= '0;
      r_wcnt   <= '0;
      r_tcnt   <= '0;
      r_pcnt   <= '0;
      r_max    <= '0;
      r_min    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_vmax   <= '0;
      r_vmin   <= '0;
      r_vpp    <= '0;
      r_period <= '0;
      r_err    <= 1'b0;
    end else begin
      r_s <= ad_data;

      if (r_state == IDLE && start) r_wcnt <= '0;

      if (r_state == PEAK) begin
        r_max  <= w_cur_max;
        r_min  <= w_cur_min;
        r_wcnt <= r_wcnt + WCW'(1);
        if (w_peak_last) begin
          r_vmax <= w_cur_max;
          r_vmin <= w_cur_min;
          r_vpp  <= w_vpp;
          r_hi   <= w_hi;
          r_lo   <= w_lo;
          r_tcnt <= '0;
          if (w_flat) begin
            r_err    <= 1'b1;
            r_period <= '0;
          end
        end
      end

      if (w_edge_st) r_tcnt <= r_tcnt + TCW'(1);

      if (r_state == TRIG0 && w_rise)
        r_pcnt <= '0;
      else if (r_state == ARM1 || r_state == TRIG1)
        r_pcnt <= r_pcnt + 12'd1;

      // A second trigger on the timeout cycle still counts as a valid period.
      if (w_hit1) begin
        r_err    <= 1'b0;
        r_period <= r_pcnt + 12'd1;
      end else if (w_tmo) begin
        r_err    <= 1'b1;
        r_period <= '0;
      end
    end
  end

  assign err    = r_err;
  assign vmax   = r_vmax;
  assign vmin   = r_vmin;
  assign vpp    = r_vpp;
  assign period = r_period;

endmodule

`default_nettype wire

// File: tb/tb_sig_meas.sv
// ============================================================================
// tb_sig_meas : scoreboard bench for sig_meas                    rev 1.0
// ============================================================================
`default_nettype none

module tb_sig_meas;

  localparam int WIN_LEN = 1024;
  localparam int HYST    = 4;
  localparam int TMO     = 4095;

  typedef struct packed {
    logic        err;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [7:0]  vpp;
    logic [11:0] period;
  } res_t;

  logic        clk, rst, start, ad_clk, busy, done, err;
  logic [7:0]  ad_data, vmax, vmin, vpp;
  logic [11:0] period;

  res_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // waveform selection: 0 square, 1 sawtooth, 2 constant, 3 noisy triangle
  int mode, per, phase, lvl_lo, lvl_hi;
  int nz[100];

  sig_meas #(.WIN_LEN(WIN_LEN), .HYST(HYST), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .ad_data(ad_data), .start(start),
    .ad_clk(ad_clk), .busy(busy), .done(done), .err(err),
    .vmax(vmax), .vmin(vmin), .vpp(vpp), .period(period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gen(input int n);
    int k, v;
    k = n % 100;
    case (mode)
      0:       v = (((n + phase) % per) < per / 2) ? lvl_lo : lvl_hi;
      1:       v = (n % 50) * 5;
      2:       v = 128;
      default: v = ((k < 50) ? 20 + 4 * k : 220 - 4 * (k - 50)) + nz[k];
    endcase
    return 8'(v);
  endfunction

  // Pushes the expected result, then streams samples until done or budget.
  task automatic measure(input logic e_err, input logic [11:0] e_per,
                         input int budget, input int restart_at,
                         output res_t got, output int lat, output bit seen);
    res_t       e;
    logic [7:0] mx, mn, v;
    mx = gen(0);
    mn = mx;
    for (int i = 1; i < WIN_LEN; i++) begin
      v = gen(i);
      if (v > mx) mx = v;
      if (v < mn) mn = v;
    end
    e.err = e_err; e.vmax = mx; e.vmin = mn; e.vpp = mx - mn; e.period = e_per;
    sb.push_back(e);
    ad_data = gen(0);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < budget) begin
      ad_data = gen(lat + 1);
      start   = (restart_at == lat + 1);
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    got = {err, vmax, vmin, vpp, period};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    ad_data = 8'h5A; start = 1'b0; rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    checks++;
    if ({busy, done, err, vmax, vmin, vpp, period} !== 39'd0)
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, err, vmax, vmin, vpp, period});
    else passed++;
    checks++;
    if (ad_clk !== clk) $display("FAIL ad_clk got=%b exp=%b", ad_clk, clk);
    else passed++;
  endtask

  task automatic test_square;
    res_t g, e; int lat; bit seen;
    mode = 0; per = 100; phase = 0; lvl_lo = 0; lvl_hi = 255;
    measure(1'b0, 12'd100, 3000, -1, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen) $display("FAIL square_timeout got=no_done exp=done");
    else if (g !== e) $display("FAIL square_result got=%h exp=%h", g, e);
    else passed++;
    idle(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL square_single_pulse got=done%b/busy%b exp=0/0", done, busy);
    else passed++;
    idle(5);
    checks++;
    if ({err, vmax, vmin, vpp, period} !== e)
      $display("FAIL square_hold got=%h exp=%h", {err, vmax, vmin, vpp, period}, e);
    else passed++;
  endtask

  task automatic test_sawtooth;
    res_t g, e; int lat; bit seen;
    mode = 1;
    measure(1'b0, 12'd50, 3000, -1, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen) $display("FAIL saw_timeout got=no_done exp=done");
    else if (g !== e || g.vpp !== 8'd245) $display("FAIL saw_result got=%h exp=%h", g, e);
    else passed++;
    idle(3);
  endtask

  task automatic test_flat;
    res_t g, e; int lat; bit seen;
    mode = 2;
    measure(1'b1, 12'd0, 3000, -1, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen) $display("FAIL const_timeout got=no_done exp=done");
    else if (g !== e) $display("FAIL const_result got=%h exp=%h", g, e);
    else passed++;
    checks++;
    if (lat < WIN_LEN || lat > WIN_LEN + 2)
      $display("FAIL const_latency got=%0d exp=%0d..%0d", lat, WIN_LEN, WIN_LEN + 2);
    else passed++;
    idle(3);
    // peak-to-peak exactly 2*HYST is flat, one LSB more is measurable
    mode = 0; per = 100; phase = 0; lvl_lo = 100; lvl_hi = 100 + 2 * HYST;
    measure(1'b1, 12'd0, 3000, -1, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e) $display("FAIL flat_edge_vpp8 got=%h exp=%h", g, e);
    else passed++;
    idle(3);
    lvl_hi = 101 + 2 * HYST;
    measure(1'b0, 12'd100, 3000, -1, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e) $display("FAIL flat_edge_vpp9 got=%h exp=%h", g, e);
    else passed++;
    idle(3);
  endtask

  task automatic test_timeout;
    res_t g, e; int lat; bit seen;
    mode = 0; per = 5000; phase = 2000; lvl_lo = 0; lvl_hi = 255;
    measure(1'b1, 12'd0, WIN_LEN + TMO + 50, -1, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen) $display("FAIL timeout_no_done got=no_done exp=done");
    else if (g !== e) $display("FAIL timeout_result got=%h exp=%h", g, e);
    else passed++;
    checks++;
    if (lat < WIN_LEN + TMO || lat > WIN_LEN + TMO + 2)
      $display("FAIL timeout_latency got=%0d exp=%0d..%0d", lat, WIN_LEN + TMO, WIN_LEN + TMO + 2);
    else passed++;
    idle(3);
  endtask

  task automatic test_noisy_triangle;
    res_t g, e; int lat; bit seen;
    mode = 3;
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < 100; i++) nz[i] = int'($urandom_range(0, 6)) - 3;
      measure(1'b0, 12'd100, 3000, -1, g, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || g !== e) $display("FAIL triangle_run%0d got=%h exp=%h", run, g, e);
      else passed++;
      idle(3);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    mode = 0; per = 100; phase = 0; lvl_lo = 0; lvl_hi = 255;
    ad_data = gen(0); start = 1'b1;
    idle(1);
    start = 1'b0;
    for (int i = 1; i <= 200; i++) begin ad_data = gen(i); idle(1); end
    checks++;
    if (busy !== 1'b1) $display("FAIL abort_busy_in_peak got=%b exp=1", busy);
    else passed++;
    rst = 1'b1; start = 1'b1;
    idle(1);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, err, vmax, vmin, vpp, period} !== 39'd0)
      $display("FAIL abort_after_reset got=%h exp=0", {busy, done, err, vmax, vmin, vpp, period});
    else passed++;
    dones = 0;
    for (int i = 0; i < 1500; i++) begin
      ad_data = gen(i);
      idle(1);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) $display("FAIL abort_no_done got=%0d exp=0", dones);
    else passed++;
  endtask

  task automatic test_back_to_back;
    res_t g, e; int lat; bit seen; int extra;
    mode = 0; per = 100; phase = 0; lvl_lo = 0; lvl_hi = 255;
    measure(1'b0, 12'd100, 3000, 300, g, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e) $display("FAIL busy_start_result got=%h exp=%h", g, e);
    else passed++;
    extra = 0;
    for (int i = 0; i < 1500; i++) begin
      idle(1);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) $display("FAIL busy_start_ignored got=%0d exp=0", extra);
    else passed++;
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    else passed++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ad_data = '0;
    mode = 2; per = 100; phase = 0; lvl_lo = 0; lvl_hi = 255;
    for (int i = 0; i < 100; i++) nz[i] = 0;
    test_reset();
    test_square();
    test_sawtooth();
    test_flat();
    test_timeout();
    test_noisy_triangle();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=stuck exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
